// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues imem requests, presents {PC+4, instr} to IF/ID; result registered one cycle after imem_ready.
// Backpressure: a stall parks at most one word in the skid and drops imem_req; redirect drains any outstanding request first.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pend_pc, pend_pc_nxt;
   logic [31:0] skid_pc4, skid_pc4_nxt;
   logic [31:0] skid_instr, skid_instr_nxt;
   logic        valid_nxt;
   logic [31:0] pc_out_nxt;
   logic [31:0] instr_nxt;
   logic        consume;
   logic        out_free;
   logic [31:0] pc_plus4;

   assign consume  = valid_out & ~stall;
   assign out_free = ~valid_out | consume;
   assign pc_plus4 = pc + 32'd4;

   // pc is left untouched during DRAIN, so it always names the in-flight request.
   assign imem_addr = pc;
   assign imem_req  = ~rst & (state != HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= FETCH;
         pc              <= RESET_PC;
         pend_pc         <= 32'd0;
         skid_pc4        <= 32'd0;
         skid_instr      <= 32'd0;
         valid_out       <= 1'b0;
         PC_out          <= 32'd0;
         instruction_out <= 32'd0;
      end else begin
         state           <= state_nxt;
         pc              <= pc_nxt;
         pend_pc         <= pend_pc_nxt;
         skid_pc4        <= skid_pc4_nxt;
         skid_instr      <= skid_instr_nxt;
         valid_out       <= valid_nxt;
         PC_out          <= pc_out_nxt;
         instruction_out <= instr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      pend_pc_nxt    = pend_pc;
      skid_pc4_nxt   = skid_pc4;
      skid_instr_nxt = skid_instr;
      valid_nxt      = valid_out;
      pc_out_nxt     = PC_out;
      instr_nxt      = instruction_out;

      if (redirect) begin
         valid_nxt  = 1'b0;
         pc_out_nxt = 32'd0;
         instr_nxt  = 32'd0;
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  pc_nxt = redirect_pc;
               end else begin
                  pend_pc_nxt = redirect_pc;
                  state_nxt   = DRAIN;
               end
            end
            DRAIN: begin
               pend_pc_nxt = redirect_pc;
               if (imem_ready) begin
                  pc_nxt    = redirect_pc;
                  state_nxt = FETCH;
               end
            end
            HOLD: begin
               pc_nxt    = redirect_pc;
               state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
         endcase
      end else begin
         if (consume) begin
            valid_nxt = 1'b0;
         end
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  pc_nxt = pc_plus4;
                  if (out_free) begin
                     valid_nxt  = 1'b1;
                     pc_out_nxt = pc_plus4;
                     instr_nxt  = imem_rdata;
                  end else begin
                     skid_pc4_nxt   = pc_plus4;
                     skid_instr_nxt = imem_rdata;
                     state_nxt      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (consume) begin
                  valid_nxt  = 1'b1;
                  pc_out_nxt = skid_pc4;
                  instr_nxt  = skid_instr;
                  state_nxt  = FETCH;
               end
            end
            DRAIN: begin
               // Returning data belongs to the abandoned path and is discarded.
               if (imem_ready) begin
                  pc_nxt    = pend_pc;
                  state_nxt = FETCH;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns instruction = address after a programmable wait count.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC_out;
   logic [31:0] instruction_out;
   logic        valid_out;

   logic [2:0]  waits;
   logic [2:0]  wait_cnt;
   int          n_vec;
   int          n_miss;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .PC_out          (PC_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ready after 'waits' idle cycles; a dropped request cancels.
   assign imem_ready = imem_req && (wait_cnt == waits);
   assign imem_rdata = imem_addr;
   always_ff @(posedge clk) begin
      if (!imem_req || imem_ready) wait_cnt <= 3'd0;
      else                         wait_cnt <= wait_cnt + 3'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [2:0] w);
      rst      = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      waits    = w;
      tick();
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_pc_out", PC_out, 32'd0);
      check("rst_instr", instruction_out, 32'd0);
      rst = 1'b0;
      #1;
      check("rel_req", {31'd0, imem_req}, 32'd1);
      check("rel_addr", imem_addr, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      waits       = 3'd0;
      @(negedge clk);

      // Zero-wait streaming, then a redirect that wraps the PC.
      do_reset(3'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("zw_valid", {31'd0, valid_out}, 32'd1);
         check("zw_pc_out", PC_out, 32'd4 * (i + 1));
         check("zw_instr", instruction_out, 32'd4 * i);
         check("zw_addr", imem_addr, 32'd4 * (i + 1));
      end
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("wrap_valid0", {31'd0, valid_out}, 32'd0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_valid1", {31'd0, valid_out}, 32'd1);
      check("wrap_pc_out", PC_out, 32'd0);
      check("wrap_instr", instruction_out, 32'hFFFF_FFFC);
      check("wrap_addr0", imem_addr, 32'd0);

      // Two wait states: address held three cycles, one instruction per three cycles.
      do_reset(3'd2);
      tick();
      check("ws_addr_c1", imem_addr, 32'd0);
      check("ws_valid_c1", {31'd0, valid_out}, 32'd0);
      tick();
      check("ws_addr_c2", imem_addr, 32'd0);
      check("ws_valid_c2", {31'd0, valid_out}, 32'd0);
      tick();
      check("ws_valid_c3", {31'd0, valid_out}, 32'd1);
      check("ws_pc_c3", PC_out, 32'd4);
      check("ws_addr_c3", imem_addr, 32'd4);
      tick();
      check("ws_valid_c4", {31'd0, valid_out}, 32'd0);
      check("ws_pc_c4", PC_out, 32'd4);
      tick();
      check("ws_valid_c5", {31'd0, valid_out}, 32'd0);
      tick();
      check("ws_valid_c6", {31'd0, valid_out}, 32'd1);
      check("ws_pc_c6", PC_out, 32'd8);
      check("ws_instr_c6", instruction_out, 32'd4);

      // Stall three cycles with data arriving: skid parks word 8, then release.
      do_reset(3'd0);
      tick();
      tick();
      check("st_pc_pre", PC_out, 32'd8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st_pc_hold", PC_out, 32'd8);
         check("st_valid", {31'd0, valid_out}, 32'd1);
         check("st_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      tick();
      check("st_pc_12", PC_out, 32'd12);
      check("st_instr_8", instruction_out, 32'd8);
      check("st_addr_12", imem_addr, 32'd12);
      tick();
      check("st_pc_16", PC_out, 32'd16);
      check("st_instr_12", instruction_out, 32'd12);

      // Redirect while the request to 0x10 is waiting.
      do_reset(3'd0);
      for (int i = 0; i < 4; i++) tick();
      check("rd_addr_pre", imem_addr, 32'h10);
      waits       = 3'd3;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("rd_valid", {31'd0, valid_out}, 32'd0);
      check("rd_instr_clr", instruction_out, 32'd0);
      check("rd_pc_clr", PC_out, 32'd0);
      check("rd_addr_d1", imem_addr, 32'h10);
      tick();
      check("rd_addr_d2", imem_addr, 32'h10);
      tick();
      check("rd_addr_d3", imem_addr, 32'h10);
      check("rd_ready_d3", {31'd0, imem_ready}, 32'd1);
      tick();
      waits = 3'd0;
      check("rd_discard", {31'd0, valid_out}, 32'd0);
      check("rd_addr_tgt", imem_addr, 32'h100);
      tick();
      check("rd_valid_tgt", {31'd0, valid_out}, 32'd1);
      check("rd_pc_tgt", PC_out, 32'h104);
      check("rd_instr_tgt", instruction_out, 32'h100);

      // Redirect together with stall while in HOLD.
      do_reset(3'd0);
      tick();
      tick();
      stall = 1'b1;
      tick();
      check("hr_req_hold", {31'd0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      check("hr_valid", {31'd0, valid_out}, 32'd0);
      check("hr_instr", instruction_out, 32'd0);
      check("hr_addr", imem_addr, 32'h200);
      tick();
      check("hr_pc_tgt", PC_out, 32'h204);
      check("hr_instr_tgt", instruction_out, 32'h200);

      // Reset asserted during DRAIN loses the pending target.
      do_reset(3'd0);
      tick();
      waits       = 3'd5;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      check("dr_addr", imem_addr, 32'd4);
      rst = 1'b1;
      tick();
      check("dr_rst_req", {31'd0, imem_req}, 32'd0);
      check("dr_rst_valid", {31'd0, valid_out}, 32'd0);
      check("dr_rst_pc", imem_addr, 32'd0);
      tick();
      rst   = 1'b0;
      waits = 3'd0;
      #1;
      check("dr_rel_req", {31'd0, imem_req}, 32'd1);
      check("dr_rel_addr", imem_addr, 32'd0);
      tick();
      check("dr_pc_out", PC_out, 32'd4);
      check("dr_instr", instruction_out, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
